bus_cycle_timer: RTL and testbench

BUS_CYCLE_TIMER -- requirements
Module: bus_cycle_timer

---
 rtl/bus_cycle_timer_if.sv | 28 ++
 rtl/bus_cycle_timer.sv | 154 +++++++++++++++
 tb/tb_bus_cycle_timer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/bus_cycle_timer_if.sv
// CPU-side bus signals for the 68000 bus-cycle timer: strobes, decoder selects,
// peripheral DTACKs and the timer's DTACK/BERR/FAULT replies.
interface bus_cycle_timer_if;
  logic AS;
  logic IACK;
  logic ROMEN;
  logic RAMEN;
  logic MFPEN;
  logic DUARTEN;
  logic DTACK_MFP_IN;
  logic DTACK_DUART_IN;
  logic CLR_FAULT;
  logic DTACK;
  logic BERR;
  logic FAULT;

  modport master (
    output AS, IACK, ROMEN, RAMEN, MFPEN, DUARTEN,
    output DTACK_MFP_IN, DTACK_DUART_IN, CLR_FAULT,
    input  DTACK, BERR, FAULT
  );

  modport slave (
    input  AS, IACK, ROMEN, RAMEN, MFPEN, DUARTEN,
    input  DTACK_MFP_IN, DTACK_DUART_IN, CLR_FAULT,
    output DTACK, BERR, FAULT
  );
endinterface

// File: rtl/bus_cycle_timer.sv
// 68000 bus-cycle timer: generates DTACK after programmed wait states or a
// peripheral acknowledge, and BERR plus a sticky FAULT on timeout.
module bus_cycle_timer #(
  parameter int unsigned ROM_WS       = 2,
  parameter int unsigned RAM_WS       = 0,
  parameter int unsigned BERR_TIMEOUT = 64
) (
  input logic              CLK,
  input logic              RST,
  bus_cycle_timer_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_EXT  = 3'd2;
  localparam logic [2:0] S_ACK  = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [1:0] SRC_NONE  = 2'd0;
  localparam logic [1:0] SRC_DUART = 2'd1;
  localparam logic [1:0] SRC_MFP   = 2'd2;

  localparam logic [3:0] LP_ROM_WS   = 4'(ROM_WS);
  localparam logic [3:0] LP_RAM_WS   = 4'(RAM_WS);
  localparam logic [7:0] LP_TO_LAST  = 8'(BERR_TIMEOUT - 1);

  logic [2:0] r_state;
  logic [2:0] w_state_nxt;
  logic [1:0] r_src;
  logic [1:0] w_src_nxt;
  logic [3:0] r_ws;
  logic [3:0] w_ws_nxt;
  logic [7:0] r_to;
  logic [7:0] w_to_nxt;
  logic [7:0] w_to_inc;
  logic       w_ack_ext;
  logic       w_timeout;
  logic       w_fault_set;
  logic       r_dtack;
  logic       r_berr;
  logic       r_fault;

  // Timeout value as it stands on this edge; compared against the last legal count.
  always_comb begin
    w_to_inc  = (r_to == 8'hFF) ? 8'hFF : (r_to + 8'd1);
    w_timeout = (w_to_inc >= LP_TO_LAST);
    w_ack_ext = ((r_src == SRC_DUART) && !bus.DTACK_DUART_IN) ||
                ((r_src == SRC_MFP)   && !bus.DTACK_MFP_IN);
  end

  // Next-state logic; acknowledge is tested before timeout so it wins a tie.
  always_comb begin
    w_state_nxt = r_state;
    w_src_nxt   = r_src;
    w_ws_nxt    = r_ws;
    w_to_nxt    = r_to;
    w_fault_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_to_nxt  = 8'd0;
        w_ws_nxt  = 4'd0;
        w_src_nxt = SRC_NONE;
        if (!bus.AS) begin
          if (!bus.ROMEN) begin
            w_ws_nxt    = LP_ROM_WS;
            w_state_nxt = (LP_ROM_WS == 4'd0) ? S_ACK : S_WAIT;
          end else if (!bus.RAMEN) begin
            w_ws_nxt    = LP_RAM_WS;
            w_state_nxt = (LP_RAM_WS == 4'd0) ? S_ACK : S_WAIT;
          end else if (!bus.DUARTEN) begin
            w_src_nxt   = SRC_DUART;
            w_state_nxt = S_EXT;
          end else if (!bus.MFPEN || !bus.IACK) begin
            w_src_nxt   = SRC_MFP;
            w_state_nxt = S_EXT;
          end else begin
            w_state_nxt = S_EXT;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        w_to_nxt = w_to_inc;
        if (bus.AS) begin
          w_state_nxt = S_IDLE;
        end else if (r_ws <= 4'd1) begin
          w_ws_nxt    = 4'd0;
          w_state_nxt = S_ACK;
        end else if (w_timeout) begin
          w_fault_set = 1'b1;
          w_state_nxt = S_ERR;
        end else begin
          w_ws_nxt = r_ws - 4'd1;
        end
      end
      S_EXT: begin
        w_to_nxt = w_to_inc;
        if (bus.AS) begin
          w_state_nxt = S_IDLE;
        end else if (w_ack_ext) begin
          w_state_nxt = S_ACK;
        end else if (w_timeout) begin
          w_fault_set = 1'b1;
          w_state_nxt = S_ERR;
        end else begin
          w_state_nxt = S_EXT;
        end
      end
      S_ACK, S_ERR: begin
        if (bus.AS) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_src   <= SRC_NONE;
      r_ws    <= 4'd0;
      r_to    <= 8'd0;
      r_dtack <= 1'b1;
      r_berr  <= 1'b1;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_src   <= w_src_nxt;
      r_ws    <= w_ws_nxt;
      r_to    <= w_to_nxt;
      r_dtack <= (w_state_nxt != S_ACK);
      r_berr  <= (w_state_nxt != S_ERR);
      if (w_fault_set) begin
        r_fault <= 1'b1;
      end else if (bus.CLR_FAULT) begin
        r_fault <= 1'b0;
      end else begin
        r_fault <= r_fault;
      end
    end
  end

  assign bus.DTACK = r_dtack;
  assign bus.BERR  = r_berr;
  assign bus.FAULT = r_fault;

endmodule

// File: tb/tb_bus_cycle_timer.sv
// Directed bench for bus_cycle_timer with default parameters (ROM_WS=2,
// RAM_WS=0, BERR_TIMEOUT=64); "edge 0" is the edge that first samples AS low.
module tb_bus_cycle_timer;
  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  bus_cycle_timer_if bus ();

  bus_cycle_timer #(
    .ROM_WS       (2),
    .RAM_WS       (0),
    .BERR_TIMEOUT (64)
  ) u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic check_out(input string tag, input logic dtack, input logic berr, input logic fault);
    check({tag, ".DTACK"}, bus.DTACK, dtack);
    check({tag, ".BERR"},  bus.BERR,  berr);
    check({tag, ".FAULT"}, bus.FAULT, fault);
  endtask

  task automatic idle_inputs();
    bus.AS             = 1'b1;
    bus.IACK           = 1'b1;
    bus.ROMEN          = 1'b1;
    bus.RAMEN          = 1'b1;
    bus.MFPEN          = 1'b1;
    bus.DUARTEN        = 1'b1;
    bus.DTACK_MFP_IN   = 1'b1;
    bus.DTACK_DUART_IN = 1'b1;
    bus.CLR_FAULT      = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();

    // Reset held with an active ROM cycle request: outputs stay inactive
    RST = 1'b0;
    bus.AS = 1'b0;
    bus.ROMEN = 1'b0;
    tick();
    tick();
    check_out("reset", 1'b1, 1'b1, 1'b0);
    idle_inputs();
    RST = 1'b1;
    tick();
    check_out("post_reset_idle", 1'b1, 1'b1, 1'b0);

    // ROM read, 2 wait states
    bus.AS = 1'b0; bus.ROMEN = 1'b0;
    tick(); check("rom.e0", bus.DTACK, 1'b1);
    tick(); check("rom.e1", bus.DTACK, 1'b1);
    tick(); check_out("rom.e2", 1'b0, 1'b1, 1'b0);
    tick(); check("rom.hold", bus.DTACK, 1'b0);
    idle_inputs();
    tick(); check("rom.release", bus.DTACK, 1'b1);

    // ROM and RAM both selected: ROM timing wins
    bus.AS = 1'b0; bus.ROMEN = 1'b0; bus.RAMEN = 1'b0;
    tick(); check("prio.e0", bus.DTACK, 1'b1);
    tick(); check("prio.e1", bus.DTACK, 1'b1);
    tick(); check("prio.e2", bus.DTACK, 1'b0);
    idle_inputs();
    tick(); check("prio.release", bus.DTACK, 1'b1);

    // RAM alone, zero wait states: DTACK right after edge 0
    bus.AS = 1'b0; bus.RAMEN = 1'b0;
    tick(); check("ram.e0", bus.DTACK, 1'b0);
    idle_inputs();
    tick(); check("ram.release", bus.DTACK, 1'b1);

    // DUART cycle acknowledged at edge 5
    bus.AS = 1'b0; bus.DUARTEN = 1'b0;
    tick(); check("duart.e0", bus.DTACK, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      tick(); check($sformatf("duart.e%0d", i), bus.DTACK, 1'b1);
    end
    bus.DTACK_DUART_IN = 1'b0;
    tick(); check_out("duart.e5", 1'b0, 1'b1, 1'b0);
    idle_inputs();
    tick(); check_out("duart.release", 1'b1, 1'b1, 1'b0);

    // Unmapped access: BERR at edge 63, sticky FAULT, cleared by CLR_FAULT
    bus.AS = 1'b0;
    tick();
    for (int i = 1; i <= 62; i++) tick();
    check_out("unmapped.e62", 1'b1, 1'b1, 1'b0);
    tick(); check_out("unmapped.e63", 1'b1, 1'b0, 1'b1);
    tick(); check("unmapped.hold", bus.BERR, 1'b0);
    bus.AS = 1'b1;
    tick(); check_out("unmapped.release", 1'b1, 1'b1, 1'b1);
    bus.CLR_FAULT = 1'b1;
    tick();
    bus.CLR_FAULT = 1'b0;
    check("unmapped.clr", bus.FAULT, 1'b0);

    // MFP acknowledge on the timeout edge: acknowledge wins
    bus.AS = 1'b0; bus.MFPEN = 1'b0;
    tick();
    for (int i = 1; i <= 62; i++) tick();
    bus.DTACK_MFP_IN = 1'b0;
    tick(); check_out("mfp_tie.e63", 1'b0, 1'b1, 1'b0);
    idle_inputs();
    tick(); check("mfp_tie.release", bus.DTACK, 1'b1);

    // IACK cycle acknowledged through the MFP DTACK
    bus.AS = 1'b0; bus.IACK = 1'b0; bus.DTACK_MFP_IN = 1'b0;
    tick(); check("iack.e0", bus.DTACK, 1'b1);
    tick(); check("iack.e1", bus.DTACK, 1'b0);
    idle_inputs();
    tick();

    // DUART DTACK must not acknowledge an MFP cycle
    bus.AS = 1'b0; bus.MFPEN = 1'b0; bus.DTACK_DUART_IN = 1'b0;
    tick();
    tick(); check("mfp_wrong_src", bus.DTACK, 1'b1);
    idle_inputs();
    tick();

    // FAULT set and CLR_FAULT on the same edge: set wins
    bus.AS = 1'b0;
    tick();
    for (int i = 1; i <= 62; i++) tick();
    bus.CLR_FAULT = 1'b1;
    tick();
    bus.CLR_FAULT = 1'b0;
    check_out("set_vs_clr", 1'b1, 1'b0, 1'b1);
    bus.AS = 1'b1;
    tick();
    bus.CLR_FAULT = 1'b1;
    tick();
    bus.CLR_FAULT = 1'b0;
    check("set_vs_clr.cleared", bus.FAULT, 1'b0);

    // Aborted DUART cycle: late DTACK with AS high does nothing
    bus.AS = 1'b0; bus.DUARTEN = 1'b0;
    tick();
    tick();
    bus.AS = 1'b1;
    tick(); check_out("abort", 1'b1, 1'b1, 1'b0);
    bus.DTACK_DUART_IN = 1'b0;
    tick(); check("abort.late_dtack", bus.DTACK, 1'b1);
    idle_inputs();
    tick();

    // Reset during WAIT with one wait state left
    bus.AS = 1'b0; bus.ROMEN = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    tick(); check_out("rst_wait", 1'b1, 1'b1, 1'b0);
    idle_inputs();
    tick();
    RST = 1'b1;
    tick(); check("rst_wait.after1", bus.DTACK, 1'b1);
    tick(); check("rst_wait.after2", bus.DTACK, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
